// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the bank arbiter: bank map, read-select encoding,
// ownership state and burst-counter helper.
package ram_arbiter_pkg;

  localparam logic [13:0] BANK0_BASE    = 14'h0000;
  localparam logic [13:0] BANK1_BASE    = 14'h2000;
  localparam logic [13:0] UNMAPPED_BASE = 14'h3000;

  typedef logic [1:0] rsel_t;
  localparam rsel_t RSEL_B0   = 2'd0;
  localparam rsel_t RSEL_B1   = 2'd1;
  localparam rsel_t RSEL_NONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic b0_hit;
    logic b1_hit;
    logic unmapped;
  } bank_hit_t;

  localparam int BURST_W = 4;
  typedef logic [BURST_W-1:0] burst_t;
  localparam burst_t BURST_ONE = 4'd1;

  // Saturating increment: the count never passes the configured burst limit.
  function automatic burst_t burst_inc(input burst_t cnt, input burst_t limit);
    burst_t nxt;
    if (cnt >= limit) begin
      nxt = limit;
    end else begin
      nxt = cnt + BURST_ONE;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of the bank arbiter; bit/byte lane i belongs to requester i.
interface ram_arbiter_if #(
  parameter int AW = 14
);
  logic [1:0]      req;
  logic [1:0]      we;
  logic [2*AW-1:0] addr;
  logic [15:0]     wdata;
  logic [1:0]      gnt;
  logic [1:0]      rvalid;
  logic [7:0]      rdata;
  logic            unmapped;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, unmapped
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, unmapped
  );
endinterface

// File: rtl/ram_arbiter_bank_decode.sv
// Address to bank decode; also usable by the monitor's address range checks.
module bank_decode
  import ram_arbiter_pkg::*;
#(
  parameter int AW    = 14,
  parameter int B0_AW = 13,
  parameter int B1_AW = 12
) (
  input  logic [AW-1:0] addr_i,
  output bank_hit_t     hit_o
);

  localparam logic [AW-1:0] B0_BASE = AW'(BANK0_BASE);
  localparam logic [AW-1:0] B1_BASE = AW'(BANK1_BASE);

  logic b0_s;
  logic b1_s;

  // A bank hits when the bits above its own address width match its base.
  assign b0_s = ((addr_i >> B0_AW) == (B0_BASE >> B0_AW));
  assign b1_s = ~b0_s & ((addr_i >> B1_AW) == (B1_BASE >> B1_AW));

  assign hit_o.b0_hit   = b0_s;
  assign hit_o.b1_hit   = b1_s;
  assign hit_o.unmapped = ~b0_s & ~b1_s;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin request/grant arbiter sharing the two blockram banks between
// the cpu (requester 0) and the monitor/DMA port (requester 1).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW        = 14,
  parameter int MAX_BURST = 4,
  parameter int B0_AW     = 13,
  parameter int B1_AW     = 12
) (
  input  logic          CLK,
  input  logic          reset,
  ram_arbiter_if.slave  bus,
  output logic          b0_we_o,
  output logic          b1_we_o,
  output logic [AW-1:0] bank_waddr_o,
  output logic [AW-1:0] bank_raddr_o,
  output logic [7:0]    bank_din_o,
  input  logic [7:0]    b0_dout_i,
  input  logic [7:0]    b1_dout_i
);

  localparam burst_t BURST_LIMIT = burst_t'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  burst_t     burst_cnt_q, burst_cnt_d;
  logic [1:0] rvalid_q, rvalid_d;
  rsel_t      rsel_q, rsel_d;
  logic       unmapped_q, unmapped_d;

  logic [1:0]    gnt_s;
  logic          gsel_s;
  logic          gwe_s;
  logic [AW-1:0] gaddr_s;
  logic [7:0]    gdata_s;
  logic [7:0]    rdata_s;
  bank_hit_t     hit_s;

  bank_decode #(
    .AW    (AW),
    .B0_AW (B0_AW),
    .B1_AW (B1_AW)
  ) u_decode (
    .addr_i (gaddr_s),
    .hit_o  (hit_s)
  );

  // Ownership state register; reset leaves requester 0 winning the first tie.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= {BURST_W{1'b0}};
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Grant decision; reset gates all grants so a reset-cycle access is dropped.
  always_comb begin
    gnt_s = 2'b00;
    if (!reset) begin
      gnt_s = 2'b00;
    end else begin
      case (bus.req)
        2'b01: gnt_s = 2'b01;
        2'b10: gnt_s = 2'b10;
        2'b11: begin
          case (state_q)
            OWN0:    gnt_s = (burst_cnt_q < BURST_LIMIT) ? 2'b01 : 2'b10;
            OWN1:    gnt_s = (burst_cnt_q < BURST_LIMIT) ? 2'b10 : 2'b01;
            default: gnt_s = last_q ? 2'b01 : 2'b10;
          endcase
        end
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Next ownership state and burst length.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    case (gnt_s)
      2'b01: begin
        state_d     = OWN0;
        last_d      = 1'b0;
        burst_cnt_d = (state_q == OWN0) ? burst_inc(burst_cnt_q, BURST_LIMIT) : BURST_ONE;
      end
      2'b10: begin
        state_d     = OWN1;
        last_d      = 1'b1;
        burst_cnt_d = (state_q == OWN1) ? burst_inc(burst_cnt_q, BURST_LIMIT) : BURST_ONE;
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = {BURST_W{1'b0}};
      end
    endcase
  end

  // Bank-side outputs for the granted requester; writes land at this edge.
  always_comb begin
    gsel_s       = gnt_s[1];
    gaddr_s      = gsel_s ? bus.addr[2*AW-1:AW] : bus.addr[AW-1:0];
    gdata_s      = gsel_s ? bus.wdata[15:8] : bus.wdata[7:0];
    gwe_s        = |(gnt_s & bus.we);
    b0_we_o      = gwe_s & hit_s.b0_hit;
    b1_we_o      = gwe_s & hit_s.b1_hit;
    bank_waddr_o = gaddr_s;
    bank_raddr_o = gaddr_s;
    bank_din_o   = gdata_s;
    rvalid_d     = gnt_s & ~bus.we;
    unmapped_d   = (|gnt_s) & hit_s.unmapped;
    if (hit_s.b0_hit) begin
      rsel_d = RSEL_B0;
    end else if (hit_s.b1_hit) begin
      rsel_d = RSEL_B1;
    end else begin
      rsel_d = RSEL_NONE;
    end
  end

  // Read-return and unmapped-flag pipeline, one cycle behind the grant.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      rvalid_q   <= 2'b00;
      rsel_q     <= RSEL_B0;
      unmapped_q <= 1'b0;
    end else begin
      rvalid_q   <= rvalid_d;
      rsel_q     <= rsel_d;
      unmapped_q <= unmapped_d;
    end
  end

  // Shared return data, forced to zero when no read is returning.
  always_comb begin
    rdata_s = 8'h00;
    if (|rvalid_q) begin
      case (rsel_q)
        RSEL_B0: rdata_s = b0_dout_i;
        RSEL_B1: rdata_s = b1_dout_i;
        default: rdata_s = 8'h00;
      endcase
    end else begin
      rdata_s = 8'h00;
    end
  end

  assign bus.gnt      = gnt_s;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_s;
  assign bus.unmapped = unmapped_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: per-cycle vector tables per scenario,
// read returns tracked through a scoreboard queue.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int AW = 14;

  logic CLK = 1'b0;
  logic reset;
  logic preload;
  always #5 CLK = ~CLK;

  ram_arbiter_if #(.AW(AW)) bus ();

  logic          b0_we, b1_we;
  logic [AW-1:0] bank_waddr, bank_raddr;
  logic [7:0]    bank_din, b0_dout, b1_dout;

  ram_arbiter #(
    .AW(AW), .MAX_BURST(4), .B0_AW(13), .B1_AW(12)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .bus          (bus),
    .b0_we_o      (b0_we),
    .b1_we_o      (b1_we),
    .bank_waddr_o (bank_waddr),
    .bank_raddr_o (bank_raddr),
    .bank_din_o   (bank_din),
    .b0_dout_i    (b0_dout),
    .b1_dout_i    (b1_dout)
  );

  // Blockram models: separate write and read ports, 1-cycle read latency.
  logic [7:0] b0_mem [0:8191];
  logic [7:0] b1_mem [0:4095];
  always @(posedge CLK) begin
    if (preload) b1_mem[0] <= 8'h3C;
    if (b0_we) b0_mem[bank_waddr[12:0]] <= bank_din;
    if (b1_we) b1_mem[bank_waddr[11:0]] <= bank_din;
    b0_dout <= b0_mem[bank_raddr[12:0]];
    b1_dout <= b1_mem[bank_raddr[11:0]];
  end

  typedef struct packed {
    logic [1:0] rv;
    logic [7:0] rd;
    logic       unm;
  } ret_t;

  typedef struct packed {
    logic        rst;
    logic [1:0]  req, we;
    logic [13:0] a0, a1;
    logic [7:0]  d0, d1;
    logic [1:0]  gnt;
    logic        b0we, b1we;
    logic [1:0]  rv;
    logic [7:0]  rd;
    logic        unm;
  } vec_t;

  ret_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mkv(input logic rst, input logic [1:0] req, input logic [1:0] we,
                               input logic [13:0] a0, input logic [13:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [1:0] gnt, input logic b0we, input logic b1we,
                               input logic [1:0] rv, input logic [7:0] rd, input logic unm);
    vec_t v;
    v = '{rst, req, we, a0, a1, d0, d1, gnt, b0we, b1we, rv, rd, unm};
    return v;
  endfunction

  // Drives one cycle of stimulus and queues the return expected after its edge.
  task automatic apply(input vec_t v);
    reset     = v.rst;
    bus.req   = v.req;
    bus.we    = v.we;
    bus.addr  = {v.a1, v.a0};
    bus.wdata = {v.d1, v.d0};
    sb_q.push_back('{v.rv, v.rd, v.unm});
  endtask

  task automatic test_reset();
    vec_t tbl[$];
    ret_t exp, got;
    tbl.push_back(mkv(1'b0, 2'b11, 2'b11, 14'h0020, 14'h2020, 8'hEE, 8'hDD, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b11, 2'b11, 14'h0020, 14'h2020, 8'hEE, 8'hDD, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      vectors++;
      if ({bus.gnt, b0_we, b1_we} !== {tbl[i].gnt, tbl[i].b0we, tbl[i].b1we}) begin
        miscompares++;
        $display("FAIL reset[%0d] grant: gnt=%b b0_we=%b b1_we=%b, expected %b %b %b", i, bus.gnt, b0_we, b1_we, tbl[i].gnt, tbl[i].b0we, tbl[i].b1we);
      end
      @(posedge CLK); #1;
      preload = 1'b0;
      exp = sb_q.pop_front();
      got = '{bus.rvalid, bus.rdata, bus.unmapped};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d] return: rvalid/rdata/unmapped=%b/%h/%b, expected %b/%h/%b", i, got.rv, got.rd, got.unm, exp.rv, exp.rd, exp.unm);
      end
    end
  endtask

  task automatic test_burst();
    vec_t tbl[$];
    ret_t exp, got;
    logic owner;
    for (int c = 0; c < 16; c++) begin
      owner = ((c / 4) % 2) == 1;
      tbl.push_back(mkv(1'b1, 2'b11, 2'b01, 14'h0100, 14'h2000, 8'(c), 8'h00,
                        owner ? 2'b10 : 2'b01, ~owner, 1'b0,
                        owner ? 2'b10 : 2'b00, owner ? 8'h3C : 8'h00, 1'b0));
    end
    tbl.push_back(mkv(1'b1, 2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      #1;
      vectors++;
      if ({bus.gnt, b0_we, b1_we} !== {tbl[i].gnt, tbl[i].b0we, tbl[i].b1we}) begin
        miscompares++;
        $display("FAIL burst[%0d] grant: gnt=%b b0_we=%b b1_we=%b, expected %b %b %b", i, bus.gnt, b0_we, b1_we, tbl[i].gnt, tbl[i].b0we, tbl[i].b1we);
      end
      @(posedge CLK); #1;
      exp = sb_q.pop_front();
      got = '{bus.rvalid, bus.rdata, bus.unmapped};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL burst[%0d] return: rvalid/rdata/unmapped=%b/%h/%b, expected %b/%h/%b", i, got.rv, got.rd, got.unm, exp.rv, exp.rd, exp.unm);
      end
    end
  endtask

  // Shared body for the single-access scenarios, with write address/data checks.
  task automatic run_table(input string nm, input vec_t tbl[$]);
    ret_t exp, got;
    logic [13:0] ga;
    logic [7:0]  gd;
    foreach (tbl[i]) begin
      apply(tbl[i]);
      ga = tbl[i].gnt[1] ? tbl[i].a1 : tbl[i].a0;
      gd = tbl[i].gnt[1] ? tbl[i].d1 : tbl[i].d0;
      #1;
      vectors++;
      if ({bus.gnt, b0_we, b1_we} !== {tbl[i].gnt, tbl[i].b0we, tbl[i].b1we}) begin
        miscompares++;
        $display("FAIL %s[%0d] grant: gnt=%b b0_we=%b b1_we=%b, expected %b %b %b", nm, i, bus.gnt, b0_we, b1_we, tbl[i].gnt, tbl[i].b0we, tbl[i].b1we);
      end
      if (tbl[i].b0we || tbl[i].b1we) begin
        vectors++;
        if ({bank_waddr, bank_din} !== {ga, gd}) begin
          miscompares++;
          $display("FAIL %s[%0d] wport: waddr=%h din=%h, expected %h %h", nm, i, bank_waddr, bank_din, ga, gd);
        end
      end
      @(posedge CLK); #1;
      exp = sb_q.pop_front();
      got = '{bus.rvalid, bus.rdata, bus.unmapped};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL %s[%0d] return: rvalid/rdata/unmapped=%b/%h/%b, expected %b/%h/%b", nm, i, got.rv, got.rd, got.unm, exp.rv, exp.rd, exp.unm);
      end
    end
  endtask

  task automatic test_write_read();
    vec_t tbl[$];
    tbl.push_back(mkv(1'b1, 2'b01, 2'b01, 14'h0010, 14'h0000, 8'hA5, 8'h00, 2'b01, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b01, 2'b00, 14'h0010, 14'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 2'b01, 8'hA5, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    run_table("write_read", tbl);
  endtask

  task automatic test_r1_read();
    vec_t tbl[$];
    tbl.push_back(mkv(1'b1, 2'b10, 2'b00, 14'h0000, 14'h2000, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0, 2'b10, 8'h3C, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    run_table("r1_read", tbl);
  endtask

  task automatic test_unmapped();
    vec_t tbl[$];
    tbl.push_back(mkv(1'b1, 2'b01, 2'b01, 14'h3004, 14'h0000, 8'h77, 8'h00, 2'b01, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1));
    tbl.push_back(mkv(1'b1, 2'b01, 2'b00, 14'h3004, 14'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 2'b01, 8'h00, 1'b1));
    tbl.push_back(mkv(1'b1, 2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    run_table("unmapped", tbl);
  endtask

  task automatic test_boundary();
    vec_t tbl[$];
    tbl.push_back(mkv(1'b1, 2'b01, 2'b01, 14'h1FFF, 14'h0000, 8'h11, 8'h00, 2'b01, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b10, 2'b10, 14'h0000, 14'h2FFF, 8'h00, 8'h22, 2'b10, 1'b0, 1'b1, 2'b00, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b01, 2'b00, 14'h1FFF, 14'h0000, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 2'b01, 8'h11, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b10, 2'b00, 14'h0000, 14'h2FFF, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0, 2'b10, 8'h22, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    run_table("boundary", tbl);
  endtask

  task automatic test_reset_mid_burst();
    vec_t tbl[$];
    tbl.push_back(mkv(1'b1, 2'b01, 2'b00, 14'h0010, 14'h2000, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 2'b01, 8'hA5, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b11, 2'b00, 14'h0010, 14'h2000, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 2'b01, 8'hA5, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b11, 2'b00, 14'h0010, 14'h2000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b11, 2'b00, 14'h0010, 14'h2000, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 2'b01, 8'hA5, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b11, 2'b00, 14'h0010, 14'h2000, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 2'b01, 8'hA5, 1'b0));
    tbl.push_back(mkv(1'b1, 2'b00, 2'b00, 14'h0000, 14'h0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0));
    run_table("reset_mid_burst", tbl);
  endtask

  initial begin
    reset     = 1'b0;
    preload   = 1'b1;
    bus.req   = 2'b00;
    bus.we    = 2'b00;
    bus.addr  = {(2*AW){1'b0}};
    bus.wdata = 16'h0000;
    test_reset();
    test_burst();
    test_write_read();
    test_r1_read();
    test_unmapped();
    test_boundary();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the two banked blockrams between two requesters: port 0 is the cpu, port 1 is the monitor or a future DMA.
- The banks are bank0 (8K, 0x0000-0x1FFF) and bank1 (4K, 0x2000-0x2FFF).
- It replaces the static running-flag mux in top with a request/grant arbiter.
- The arbiter does round-robin with a bounded burst, bank decode, a 1-cycle read-return path and unmapped-address detection.

Parameters:
- AW, 14, requester address width (byte address).
- MAX_BURST, 4, maximum consecutive grants to one owner while the other requester waits; 1..15.
- B0_AW, 13, bank0 address width.
- B1_AW, 12, bank1 address width.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-low.
- req  in  2  per-requester access request; bit i = requester i.
- we  in  2  1 = write, 0 = read; sampled with req.
- addr  in  2*AW  requester addresses; [AW-1:0] = r0.
- wdata  in  16  write data; [7:0] = r0.
- gnt  out  2  one-hot or zero; access is performed at the edge ending the cycle.
- rvalid  out  2  one-cycle pulse: read data for requester i is on rdata.
- rdata  out  8  read data; shared by both requesters, qualified by rvalid.
- unmapped  out  1  one-cycle pulse one cycle after a granted access to 0x3000-0x3FFF.
- b0_we  out  1  bank0 write enable.
- b1_we  out  1  bank1 write enable.
- bank_waddr  out  AW  address to banks; each bank takes its low bits.
- bank_raddr  out  AW  address to banks; each bank takes its low bits.
- bank_din  out  8  bank write data.
- b0_dout  in  8  bank0 read data, 1-cycle latency.
- b1_dout  in  8  bank1 read data, 1-cycle latency.

Behaviour:
- Reset is synchronous, active-low on reset; clock is CLK.
- While reset=0:
  - gnt=0, b0_we=b1_we=0 (combinationally gated; a write presented in the reset cycle is dropped).
  - At the edge: state<=IDLE, last<=1, burst_cnt<=0, rvalid<=0, unmapped<=0, rsel_q<=0.
- State machine, registered: IDLE, OWN0, OWN1. It records the requester granted in the previous cycle.
- Grant decision is combinational from req, state, last and burst_cnt:
  - Only req[i] asserted: gnt[i]=1.
  - Both asserted, state=OWNk and burst_cnt<MAX_BURST: gnt[k]=1 (owner continues).
  - Both asserted, state=OWNk and burst_cnt>=MAX_BURST: gnt[1-k]=1.
  - Both asserted, state=IDLE: gnt[1-last]=1. After reset r0 wins the first tie.
  - Neither asserted: gnt=0; next state IDLE.
- Transitions on the edge:
  - gnt[i]=1: state<=OWNi, last<=i.
  - burst_cnt<=1 on a change of owner or from IDLE; otherwise burst_cnt+1, saturating at MAX_BURST.
  - No grant: state<=IDLE, burst_cnt<=0, last unchanged.
- burst_cnt width is 4 bits.
- Bank decode uses the granted address a:
  - a[13]=0 → bank0.
  - a[13:12]=2'b10 → bank1.
  - a[13:12]=2'b11 → unmapped: writes dropped, reads return 8'h00, unmapped pulses next cycle.
- Write path:
  - bank_waddr=a, bank_din=granted wdata.
  - bX_we = gnt & we & decode; the write lands at the same edge. Zero latency.
- Read path:
  - bank_raddr=a whenever granted.
  - At the edge: rvalid[i]<=gnt[i]&~we[i]; rsel_q<=decode (0=b0, 1=b1, 2=unmapped).
  - Next cycle: rdata = rsel_q mux of b0_dout/b1_dout/8'h00 when |rvalid, else 8'h00.
  - Read latency is exactly 1 cycle after grant.
  - Back-to-back reads by either requester give rvalid every cycle.
- A write and a read in consecutive cycles to the same address: the read returns the new data. The bank's separate write/read ports guarantee this because the write precedes the read edge.
- Without gnt the requester must hold req/we/addr/wdata stable; the arbiter does not latch requests.
- Reset asserted while rvalid is pending: rvalid forced to 0 next edge; the pending data is lost.
- No combinational path from rdata/rvalid back to req within the arbiter.

Decomposition:
- Shared package holds:
  - Bank map constants: BANK0_BASE 14'h0000, BANK1_BASE 14'h2000, UNMAPPED_BASE 14'h3000.
  - The rsel encoding localparams: RSEL_B0, RSEL_B1, RSEL_NONE.
  - The state encoding: IDLE, OWN0, OWN1.
- One natural sub-module, bank_decode: combinational address → {b0_hit, b1_hit, unmapped}. It is reused by the monitor's address range checks.

Test Plan:
- Reset, then r0 write 0x0010=8'hA5, then r0 read 0x0010 → gnt[0] both cycles; b0_we pulse; rvalid[0] one cycle after the read grant with rdata=8'hA5.
- Both req held continuously from IDLE, MAX_BURST=4 → grant sequence r0×4, r1×4, r0×4…; no cycle without a grant.
- r1 alone reads 0x2000 preloaded 8'h3C → rvalid[1] next cycle, rdata=8'h3C, b0_we/b1_we never asserted.
- r0 writes 0x3004 then reads 0x3004 → no bank we; unmapped pulses after each; read rdata=8'h00.
- Write 0x1FFF=8'h11 and 0x2FFF=8'h22, read both back → 8'h11 from bank0, 8'h22 from bank1; bank-boundary decode correct.
- Both requesting, reset driven low for 1 cycle mid-burst with a read in flight → gnt=0 during reset; rvalid=0 after the edge; first post-reset tie granted to r0.
